// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: column bus widths and the column loader state encoding.
package gemm_pkg;

   localparam int unsigned COL_DATA_W  = 512;
   localparam int unsigned COL_SLICE_W = 64;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } loader_state_t;

endpackage : gemm_pkg

// File: rtl/col_bram_loader.sv
// Column stream to ping/pong BRAM write controller; owns the bank select and
// swaps banks only when the fill bank is complete and the read bank is released.
module col_bram_loader
   import gemm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned NUM_BRAM   = 8,
   parameter int unsigned NUM_COLS   = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COL_DATA_W-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  rd_release,
   output logic                  mat_ready,
   output logic [NUM_BRAM-1:0]   bram_ena,
   output logic [NUM_BRAM-1:0]   bram_wea,
   output logic [ADDR_WIDTH-1:0] bram_addra,
   output logic [COL_DATA_W-1:0] bram_dina,
   output logic                  ping_pong_sel,
   output logic                  ping_pong_sel_d3
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COLS - 1);

   loader_state_t         state;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [2:0]            sel_pipe;
   logic                  accept_c;
   logic                  swap_c;

   assign accept_c = s_tvalid & s_tready;
   // A release arriving with a swap hands the newly filled bank straight to the reader.
   assign swap_c   = (state == FULL) & (~mat_ready | rd_release);

   assign ping_pong_sel_d3 = sel_pipe[2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FILL;
         wr_addr       <= '0;
         s_tready      <= 1'b0;
         mat_ready     <= 1'b0;
         ping_pong_sel <= 1'b0;
         sel_pipe      <= '0;
         bram_ena      <= '0;
         bram_wea      <= '0;
         bram_addra    <= '0;
         bram_dina     <= '0;
      end else begin
         bram_ena <= {NUM_BRAM{accept_c}};
         bram_wea <= {NUM_BRAM{accept_c}};
         if (accept_c) begin
            bram_addra <= wr_addr;
            bram_dina  <= s_tdata;
         end

         sel_pipe <= {sel_pipe[1:0], ping_pong_sel};

         if (swap_c) begin
            mat_ready <= 1'b1;
         end else if (rd_release) begin
            mat_ready <= 1'b0;
         end

         case (state)
            FILL: begin
               s_tready <= 1'b1;
               if (accept_c) begin
                  if (wr_addr == LAST_ADDR) begin
                     wr_addr  <= '0;
                     state    <= FULL;
                     s_tready <= 1'b0;
                  end else begin
                     wr_addr <= wr_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            FULL: begin
               s_tready <= 1'b0;
               if (swap_c) begin
                  ping_pong_sel <= ~ping_pong_sel;
                  state         <= FILL;
                  s_tready      <= 1'b1;
               end
            end
            default: begin
               state    <= FILL;
               s_tready <= 1'b1;
            end
         endcase
      end
   end

endmodule : col_bram_loader

// File: tb/tb_col_bram_loader.sv
// Directed bench for col_bram_loader: fills, bank swaps, release handling, gaps and reset.
module tb_col_bram_loader;

   logic         clk;
   logic         rst;
   logic [511:0] s_tdata;
   logic         s_tvalid;
   logic         s_tready;
   logic         rd_release;
   logic         mat_ready;
   logic [7:0]   bram_ena;
   logic [7:0]   bram_wea;
   logic [8:0]   bram_addra;
   logic [511:0] bram_dina;
   logic         ping_pong_sel;
   logic         ping_pong_sel_d3;

   int checks = 0;
   int errors = 0;
   int next_addr = 0;

   col_bram_loader #(
      .ADDR_WIDTH(9),
      .NUM_BRAM  (8),
      .NUM_COLS  (512)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_tdata         (s_tdata),
      .s_tvalid        (s_tvalid),
      .s_tready        (s_tready),
      .rd_release      (rd_release),
      .mat_ready       (mat_ready),
      .bram_ena        (bram_ena),
      .bram_wea        (bram_wea),
      .bram_addra      (bram_addra),
      .bram_dina       (bram_dina),
      .ping_pong_sel   (ping_pong_sel),
      .ping_pong_sel_d3(ping_pong_sel_d3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_tvalid = 1'b0; rd_release = 1'b0; s_tdata = '0;
      repeat (3) step();
      checks++;
      if (s_tready !== 1'b0 || mat_ready !== 1'b0 || ping_pong_sel !== 1'b0 ||
          ping_pong_sel_d3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: tready=%b mat_ready=%b sel=%b sel_d3=%b, required all 0",
                  s_tready, mat_ready, ping_pong_sel, ping_pong_sel_d3);
      end
      checks++;
      if (bram_ena !== 8'h00 || bram_wea !== 8'h00 || bram_addra !== 9'd0 || bram_dina !== 512'd0) begin
         errors++;
         $display("FAIL reset_bram: ena=%h wea=%h addr=%0d dina_lo=%h, required all 0",
                  bram_ena, bram_wea, bram_addra, bram_dina[31:0]);
      end
      rst = 1'b0;
      step();
      checks++;
      if (s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_tready: got %b, required 1", s_tready);
      end
   endtask

   task automatic test_first_matrix();
      for (int i = 0; i < 512; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 512'(i);
         step();
         checks++;
         if (bram_ena !== 8'hFF || bram_wea !== 8'hFF || bram_addra !== 9'(i) ||
             bram_dina !== 512'(i) || ping_pong_sel !== 1'b0) begin
            errors++;
            $display("FAIL first_write[%0d]: ena=%h wea=%h addr=%0d dina_lo=%h sel=%b, required ena=ff addr=%0d dina=%0d sel=0",
                     i, bram_ena, bram_wea, bram_addra, bram_dina[31:0], ping_pong_sel, i, i);
         end
      end
      s_tvalid = 1'b0;
      checks++;
      if (s_tready !== 1'b0 || ping_pong_sel !== 1'b0 || mat_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_full: tready=%b sel=%b mat_ready=%b, required 0 0 0",
                  s_tready, ping_pong_sel, mat_ready);
      end
      step();
      checks++;
      if (ping_pong_sel !== 1'b1 || mat_ready !== 1'b1 || s_tready !== 1'b1 || bram_ena !== 8'h00) begin
         errors++;
         $display("FAIL first_swap: sel=%b mat_ready=%b tready=%b ena=%h, required 1 1 1 00",
                  ping_pong_sel, mat_ready, s_tready, bram_ena);
      end
      step();
      step();
      checks++;
      if (ping_pong_sel_d3 !== 1'b0) begin
         errors++;
         $display("FAIL sel_d3_early: got %b, required 0", ping_pong_sel_d3);
      end
      step();
      checks++;
      if (ping_pong_sel_d3 !== 1'b1) begin
         errors++;
         $display("FAIL sel_d3_delay: got %b, required 1", ping_pong_sel_d3);
      end
   endtask

   task automatic test_second_no_release();
      for (int i = 0; i < 512; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 512'(1000 + i);
         step();
         checks++;
         if (bram_ena !== 8'hFF || bram_addra !== 9'(i) || bram_dina !== 512'(1000 + i) ||
             ping_pong_sel !== 1'b1) begin
            errors++;
            $display("FAIL second_write[%0d]: ena=%h addr=%0d dina_lo=%h sel=%b, required ena=ff addr=%0d dina=%0d sel=1",
                     i, bram_ena, bram_addra, bram_dina[31:0], ping_pong_sel, i, 1000 + i);
         end
      end
      for (int c = 0; c < 20; c++) begin
         s_tdata = 512'(5000 + c);
         step();
         checks++;
         if (s_tready !== 1'b0 || bram_ena !== 8'h00 || ping_pong_sel !== 1'b1 || mat_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_full[%0d]: tready=%b ena=%h sel=%b mat_ready=%b, required 0 00 1 1",
                     c, s_tready, bram_ena, ping_pong_sel, mat_ready);
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_release_in_full();
      rd_release = 1'b1;
      step();
      rd_release = 1'b0;
      checks++;
      if (ping_pong_sel !== 1'b0 || mat_ready !== 1'b1 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL release_full: sel=%b mat_ready=%b tready=%b, required 0 1 1",
                  ping_pong_sel, mat_ready, s_tready);
      end
   endtask

   task automatic test_release_in_fill();
      rd_release = 1'b1;
      step();
      rd_release = 1'b0;
      checks++;
      if (mat_ready !== 1'b0 || ping_pong_sel !== 1'b0 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL release_fill: mat_ready=%b sel=%b tready=%b, required 0 0 1",
                  mat_ready, ping_pong_sel, s_tready);
      end
      for (int i = 0; i < 512; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 512'(2000 + i);
         step();
         checks++;
         if (bram_ena !== 8'hFF || bram_addra !== 9'(i) || bram_dina !== 512'(2000 + i)) begin
            errors++;
            $display("FAIL third_write[%0d]: ena=%h addr=%0d dina_lo=%h, required ena=ff addr=%0d dina=%0d",
                     i, bram_ena, bram_addra, bram_dina[31:0], i, 2000 + i);
         end
      end
      s_tvalid = 1'b0;
      checks++;
      if (ping_pong_sel !== 1'b0 || mat_ready !== 1'b0 || s_tready !== 1'b0) begin
         errors++;
         $display("FAIL third_full: sel=%b mat_ready=%b tready=%b, required 0 0 0",
                  ping_pong_sel, mat_ready, s_tready);
      end
      step();
      checks++;
      if (ping_pong_sel !== 1'b1 || mat_ready !== 1'b1 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL auto_swap: sel=%b mat_ready=%b tready=%b, required 1 1 1",
                  ping_pong_sel, mat_ready, s_tready);
      end
   endtask

   task automatic test_reset_mid_fill();
      for (int i = 0; i < 200; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 512'(4000 + i);
         step();
         checks++;
         if (bram_addra !== 9'(i) || bram_dina !== 512'(4000 + i) || ping_pong_sel !== 1'b1) begin
            errors++;
            $display("FAIL partial_write[%0d]: addr=%0d dina_lo=%h sel=%b, required addr=%0d dina=%0d sel=1",
                     i, bram_addra, bram_dina[31:0], ping_pong_sel, i, 4000 + i);
         end
      end
      s_tdata = 512'(4200);
      rst     = 1'b1;
      step();
      checks++;
      if (s_tready !== 1'b0 || mat_ready !== 1'b0 || ping_pong_sel !== 1'b0 || ping_pong_sel_d3 !== 1'b0 ||
          bram_ena !== 8'h00 || bram_wea !== 8'h00 || bram_addra !== 9'd0 || bram_dina !== 512'd0) begin
         errors++;
         $display("FAIL mid_reset: tready=%b mat_ready=%b sel=%b d3=%b ena=%h wea=%h addr=%0d dina_lo=%h, required all 0",
                  s_tready, mat_ready, ping_pong_sel, ping_pong_sel_d3, bram_ena, bram_wea,
                  bram_addra, bram_dina[31:0]);
      end
      rst      = 1'b0;
      s_tvalid = 1'b0;
      step();
      checks++;
      if (s_tready !== 1'b1 || bram_ena !== 8'h00) begin
         errors++;
         $display("FAIL post_reset: tready=%b ena=%h, required 1 00", s_tready, bram_ena);
      end
      s_tvalid = 1'b1;
      s_tdata  = 512'(77);
      step();
      s_tvalid = 1'b0;
      checks++;
      if (bram_ena !== 8'hFF || bram_addra !== 9'd0 || bram_dina !== 512'(77) || ping_pong_sel !== 1'b0) begin
         errors++;
         $display("FAIL restart_write: ena=%h addr=%0d dina_lo=%h sel=%b, required ff 0 77 0",
                  bram_ena, bram_addra, bram_dina[31:0], ping_pong_sel);
      end
      next_addr = 1;
   endtask

   task automatic test_gaps();
      int  cycles = 0;
      logic v;
      while (next_addr < 512 && cycles < 5000) begin
         v        = ($urandom_range(0, 99) >= 30);
         s_tvalid = v;
         s_tdata  = 512'(3000 + next_addr);
         step();
         cycles++;
         checks++;
         if (v) begin
            if (bram_ena !== 8'hFF || bram_addra !== 9'(next_addr) || bram_dina !== 512'(3000 + next_addr)) begin
               errors++;
               $display("FAIL gap_write[%0d]: ena=%h addr=%0d dina_lo=%h, required ena=ff addr=%0d dina=%0d",
                        next_addr, bram_ena, bram_addra, bram_dina[31:0], next_addr, 3000 + next_addr);
            end
            next_addr++;
         end else if (bram_ena !== 8'h00 || bram_wea !== 8'h00) begin
            errors++;
            $display("FAIL gap_idle: ena=%h wea=%h, required 00 00", bram_ena, bram_wea);
         end
      end
      s_tvalid = 1'b0;
      checks++;
      if (next_addr != 512) begin
         errors++;
         $display("FAIL gap_timeout: wrote %0d columns, required 512", next_addr);
      end
      step();
      checks++;
      if (ping_pong_sel !== 1'b1 || mat_ready !== 1'b1 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL gap_swap: sel=%b mat_ready=%b tready=%b, required 1 1 1",
                  ping_pong_sel, mat_ready, s_tready);
      end
   endtask

   initial begin
      test_reset();
      test_first_matrix();
      test_second_no_release();
      test_release_in_full();
      test_release_in_fill();
      test_reset_mid_fill();
      test_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_col_bram_loader
